// File: rtl/vga_regs_pkg.sv
// vga_regs_pkg: shared address offsets, CTRL bit positions and commit states
// for the VGA shadow register file.
package vga_regs_pkg;

   localparam int CTRL_ARM    = 0;
   localparam int CTRL_IRQ_EN = 1;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ARMED  = 2'b01,
      COMMIT = 2'b10
   } commit_state_t;

   // Offsets are 9 bits wide so a Port_ID below BASE_PORT wraps out of range
   function automatic logic [8:0] ofs_ctrl(int num_regs);
      return 9'(num_regs);
   endfunction

   function automatic logic [8:0] ofs_status(int num_regs);
      return 9'(num_regs + 1);
   endfunction

   function automatic logic [8:0] ofs_frame(int num_regs);
      return 9'(num_regs + 2);
   endfunction

endpackage

// File: rtl/vga_vsync_edge.sv
// vga_vsync_edge: one-cycle VSync falling-edge detector; clears to 0 so a
// low VSync at reset release is not seen as an edge.
module vga_vsync_edge (
   input  logic CLK,
   input  logic RESET,
   input  logic VSync,
   output logic fall
);

   logic vsync_d;

   always_ff @(posedge CLK or negedge RESET)
      if (!RESET) vsync_d <= 1'b0;
      else vsync_d <= VSync;

   assign fall = vsync_d & ~VSync;

endmodule

// File: rtl/vga_shadow_regfile.sv
// vga_shadow_regfile: PicoBlaze shadow registers copied atomically into the
// active bank on an armed VSync fall, plus frame counter and frame IRQ.
module vga_shadow_regfile
   import vga_regs_pkg::*;
#(
   parameter int         NUM_REGS  = 16,
   parameter logic [7:0] BASE_PORT = 8'h10
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [7:0]            Port_ID,
   input  logic [7:0]            IN_DATA,
   input  logic                  Write_Strobe,
   input  logic                  Read_Strobe,
   input  logic                  VSync,
   input  logic                  Interrupt_Ack,
   output logic [7:0]            OUT_DATA,
   output logic                  IRQ,
   output logic [8*NUM_REGS-1:0] Active,
   output logic                  Commit,
   output logic [7:0]            FrameCount
);

   localparam int         IW       = $clog2(NUM_REGS);
   localparam logic [8:0] A_CTRL   = ofs_ctrl(NUM_REGS);
   localparam logic [8:0] A_STATUS = ofs_status(NUM_REGS);
   localparam logic [8:0] A_FRAME  = ofs_frame(NUM_REGS);

   logic [7:0]    shadow [NUM_REGS];
   logic [8:0]    ofs;
   logic [7:0]    rd_data;
   logic          fall, wr_shadow, wr_ctrl, arm_bit, irq_en, go;
   commit_state_t state, state_nx;

   vga_vsync_edge u_edge (
      .CLK   (CLK),
      .RESET (RESET),
      .VSync (VSync),
      .fall  (fall)
   );

   assign ofs       = {1'b0, Port_ID} - {1'b0, BASE_PORT};
   assign wr_shadow = Write_Strobe && ofs < A_CTRL;
   assign wr_ctrl   = Write_Strobe && ofs == A_CTRL;
   assign go        = state == ARMED && state_nx == COMMIT;
   assign Commit    = state == COMMIT;

   // A disarm write wins over a coincident fall: software asked for no copy
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (wr_ctrl && IN_DATA[CTRL_ARM]) state_nx = ARMED;
         ARMED:   if (wr_ctrl && !IN_DATA[CTRL_ARM]) state_nx = IDLE;
                  else if (fall) state_nx = COMMIT;
         default: state_nx = (wr_ctrl && IN_DATA[CTRL_ARM]) ? ARMED : IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET)
      if (!RESET) state <= IDLE;
      else state <= state_nx;

   always_comb begin
      rd_data = 8'h00;
      if (ofs < A_CTRL) rd_data = shadow[ofs[IW-1:0]];
      else if (ofs == A_CTRL) rd_data = {6'b0, irq_en, arm_bit};
      else if (ofs == A_STATUS) rd_data = {state == ARMED, IRQ, irq_en, VSync, 4'b0};
      else if (ofs == A_FRAME) rd_data = FrameCount;
   end

   // Copy reads the pre-write shadow, so a same-edge write lands next frame
   always_ff @(posedge CLK or negedge RESET)
      if (!RESET) begin
         for (int i = 0; i < NUM_REGS; i++) shadow[i] <= 8'h00;
         Active <= '0;
      end else begin
         if (go)
            for (int i = 0; i < NUM_REGS; i++) Active[8*i +: 8] <= shadow[i];
         if (wr_shadow) shadow[ofs[IW-1:0]] <= IN_DATA;
      end

   always_ff @(posedge CLK or negedge RESET)
      if (!RESET) begin
         arm_bit    <= 1'b0;
         irq_en     <= 1'b0;
         IRQ        <= 1'b0;
         FrameCount <= 8'h00;
         OUT_DATA   <= 8'h00;
      end else begin
         if (wr_ctrl) begin
            arm_bit <= IN_DATA[CTRL_ARM];
            irq_en  <= IN_DATA[CTRL_IRQ_EN];
         end
         if (fall && irq_en) IRQ <= 1'b1;
         else if (Interrupt_Ack || (wr_ctrl && !IN_DATA[CTRL_IRQ_EN])) IRQ <= 1'b0;
         FrameCount <= FrameCount + {7'b0, fall};
         if (Read_Strobe) OUT_DATA <= rd_data;
      end

endmodule

// File: doc/vga_shadow_regfile.md
# vga_shadow_regfile

PicoBlaze-side shadow register file feeding the VGA pointer stage of the VGA controller. Port writes land in shadow registers. A commit is armed by software; at the next VSync falling edge all shadow values are copied atomically into the active bank that the pointer stage reads. This gives tear-free frame updates. The block also raises a per-frame IRQ to the PicoBlaze with an acknowledge handshake.

## Interface
- NUM_REGS, 16, number of shadow/active 8-bit registers (2..64)
- BASE_PORT, 8'h10, first Port_ID decoded; block owns BASE_PORT..BASE_PORT+NUM_REGS+2
- CLK  in  1  system clock, same domain as the sync counters
- RESET  in  1  asynchronous, active-low reset
- Port_ID  in  8  PicoBlaze port address
- IN_DATA  in  8  PicoBlaze write data
- Write_Strobe  in  1  one-cycle write qualifier
- Read_Strobe  in  1  one-cycle read qualifier
- VSync  in  1  vertical sync from the sync counters, active low
- Interrupt_Ack  in  1  PicoBlaze interrupt acknowledge, one-cycle pulse
- OUT_DATA  out  8  registered read data
- IRQ  out  1  frame interrupt request, level, held until acknowledged
- Active  out  8*NUM_REGS  active bank, register i at bits [8i+7:8i]
- Commit  out  1  one-cycle pulse, first cycle the new Active values are valid
- FrameCount  out  8  VSync falling edges since reset, wraps 255 -> 0

## Operation
- Address map, as offset from BASE_PORT:
  - 0..NUM_REGS-1: shadow[i], read/write.
  - NUM_REGS: CTRL, read/write. bit0 = ARM, bit1 = IRQ_EN, other bits read 0.
  - NUM_REGS+1: STATUS, read-only. Bits {armed, irq, irq_en, VSync, 4'b0}.
  - NUM_REGS+2: FrameCount, read-only.
  - Writes to read-only or unmapped addresses are ignored. Reads of unmapped addresses return 8'h00.
- Shadow write: on Write_Strobe with an offset in range, shadow[offset] <= IN_DATA.
- Edge detect: vsync_d is a 1-cycle delayed copy of VSync. fall = vsync_d & ~VSync.
- Commit FSM, states IDLE, ARMED, COMMIT:
  - IDLE -> ARMED: CTRL write with bit0=1.
  - ARMED -> IDLE: CTRL write with bit0=0 (disarm, no copy).
  - ARMED -> COMMIT: on fall. Active <= shadow (whole bank) on the same edge.
  - COMMIT -> IDLE: unconditionally after 1 cycle. A CTRL ARM write received during COMMIT goes to ARMED instead.
  - Commit = 1 only in COMMIT.
  - "armed" status bit = (state == ARMED).
- IRQ:
  - Set on fall when IRQ_EN = 1.
  - Cleared by Interrupt_Ack, or by a CTRL write with bit1=0.
  - Set has priority over a simultaneous Ack.
- FrameCount increments on every fall, independent of ARM and IRQ_EN.
- Simultaneous events:
  - Shadow write in the same cycle as the commit edge: Active takes the pre-write shadow value; the shadow holds the new value.
  - ARM write in the same cycle as fall while IDLE: no commit this frame; state goes to ARMED and commits at the next fall.
- Reset (async, active-low, at any time including mid-COMMIT):
  - shadow, Active, OUT_DATA, FrameCount, CTRL bits: 0.
  - IRQ = 0, Commit = 0, state = IDLE.
  - vsync_d = 0, so releasing reset while VSync is low produces no false fall.

## Timing
- Write latency: shadow and CTRL are updated at the clock edge ending the Write_Strobe cycle.
- Read latency: OUT_DATA is loaded at the edge ending the Read_Strobe cycle (valid 1 cycle later). It holds its value between reads.
- VSync falls in cycle t:
  - fall is asserted in cycle t.
  - Active, IRQ, FrameCount and state COMMIT all update at the edge ending t.
  - Commit is high for cycle t+1 only.
- Active is stable for a whole frame between commits, because it only changes on a fall edge.

## Structure
- Shared package vga_regs_pkg:
  - Offsets OFS_CTRL = NUM_REGS, OFS_STATUS = NUM_REGS+1, OFS_FRAME = NUM_REGS+2, written as functions of NUM_REGS.
  - CTRL bit indices CTRL_ARM = 0, CTRL_IRQ_EN = 1.
  - Commit state encoding: IDLE = 2'b00, ARMED = 2'b01, COMMIT = 2'b10.
- One sub-module, vga_vsync_edge: registers vsync_d and outputs fall, reset value 0.
- Everything else stays in the top module.

## Test plan
- Reset release with VSync = 0, then hold VSync low for 10 cycles -> no fall, FrameCount = 0, IRQ = 0, Active all 0.
- Write shadow[3] = 8'hA5, write CTRL = 8'h01, then VSync 1 -> 0 at cycle t -> Active[31:24] = 8'hA5 from t+1, Commit high only in t+1, STATUS armed = 0 afterwards.
- With CTRL = 8'h01, write shadow[0] = 8'h3C in the same cycle VSync falls -> Active[7:0] = old value (8'h00), reading shadow[0] returns 8'h3C, state IDLE.
- CTRL = 8'h02 with two VSync falls -> IRQ rises the cycle after the first fall. An Interrupt_Ack pulse clears it. An Ack coincident with the second fall leaves IRQ = 1. FrameCount = 2.
- Write CTRL = 8'h01, then CTRL = 8'h00, then VSync falls -> Active unchanged, no Commit pulse.
- Run 257 VSync falls -> FrameCount reads 8'h01 at port BASE_PORT+NUM_REGS+2, with OUT_DATA valid 1 cycle after Read_Strobe.
